// File: rtl/lw_sha256_ctrl.sv
// Block sequencer for the lightweight SHA-224/256 compression datapath.
// It runs IV load, message intake, 64 rounds with K/schedule control, and the final digest add.
module lw_sha256_ctrl #(
  parameter int WORD_SIZE = 32,
  parameter int ROUNDS    = 64,
  parameter int MSG_WORDS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 cont_i,
  input  logic                 mode224_i,
  input  logic                 msg_valid_i,
  output logic                 msg_ready_o,
  input  logic [4:0]           rnd_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 iv_load_o,
  output logic                 iv_sel_o,
  output logic                 w_wr_o,
  output logic [3:0]           w_idx_o,
  output logic                 w_expand_o,
  output logic [4:0]           rot_o,
  output logic                 round_en_o,
  output logic [5:0]           round_o,
  output logic [WORD_SIZE-1:0] k_o,
  output logic                 fin_en_o,
  output logic [2:0]           fin_idx_o
);

  typedef enum logic [2:0] {IDLE, IV, MSG, ROUND, FIN, DONE} state_t;

  localparam logic [WORD_SIZE-1:0] K256 [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t     state, state_n;
  logic [3:0] wcnt;
  logic [5:0] rcnt;
  logic [2:0] fcnt;
  logic       chain_ok;

  // Counters wrap to zero on their terminal count, so they are already cleared for the next block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wcnt     <= '0;
      rcnt     <= '0;
      fcnt     <= '0;
      chain_ok <= 1'b0;
      iv_sel_o <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start_i) iv_sel_o <= mode224_i;
      if (state == MSG && msg_valid_i) wcnt <= wcnt + 4'd1;
      if (state == ROUND) rcnt <= rcnt + 6'd1;
      if (state == FIN) fcnt <= fcnt + 3'd1;
      if (state == DONE) chain_ok <= 1'b1;
    end
  end

  always_comb begin
    state_n     = state;
    msg_ready_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    iv_load_o   = 1'b0;
    w_wr_o      = 1'b0;
    w_idx_o     = '0;
    w_expand_o  = 1'b0;
    rot_o       = '0;
    round_en_o  = 1'b0;
    round_o     = '0;
    k_o         = '0;
    fin_en_o    = 1'b0;
    fin_idx_o   = '0;
    unique case (state)
      IDLE: begin
        if (start_i) state_n = IV;
        else if (cont_i && chain_ok) state_n = MSG;
      end
      IV: begin
        busy_o    = 1'b1;
        iv_load_o = 1'b1;
        state_n   = MSG;
      end
      MSG: begin
        busy_o      = 1'b1;
        msg_ready_o = 1'b1;
        if (msg_valid_i) begin
          w_wr_o  = 1'b1;
          w_idx_o = wcnt;
          rot_o   = rnd_i;
          if (wcnt == 4'(MSG_WORDS - 1)) state_n = ROUND;
        end
      end
      ROUND: begin
        busy_o     = 1'b1;
        round_en_o = 1'b1;
        round_o    = rcnt;
        k_o        = K256[rcnt];
        // Rounds 16..63 also store the expanded schedule word W[t] over slot t mod 16.
        if (rcnt[5:4] != 2'b00) begin
          w_wr_o     = 1'b1;
          w_expand_o = 1'b1;
          w_idx_o    = rcnt[3:0];
          rot_o      = rnd_i;
        end
        if (rcnt == 6'(ROUNDS - 1)) state_n = FIN;
      end
      FIN: begin
        busy_o    = 1'b1;
        fin_en_o  = 1'b1;
        fin_idx_o = fcnt;
        if (fcnt == 3'd7) state_n = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lw_sha256_ctrl.sv
// Directed/randomized bench for lw_sha256_ctrl; K values are derived from the cube roots of the
// first 64 primes and the block schedule is modelled as phase lengths (IV, 16 words, 64, 8, done).
module tb_lw_sha256_ctrl;
  logic        clk = 1'b0;
  logic        rst, start_i, cont_i, mode224_i, msg_valid_i;
  logic [4:0]  rnd_i;
  logic        msg_ready_o, busy_o, done_o, iv_load_o, iv_sel_o, w_wr_o, w_expand_o;
  logic        round_en_o, fin_en_o;
  logic [3:0]  w_idx_o;
  logic [4:0]  rot_o;
  logic [5:0]  round_o;
  logic [31:0] k_o;
  logic [2:0]  fin_idx_o;

  int          n_pass = 0;
  int          n_fail = 0;
  int          n_tot  = 0;
  logic [31:0] kref [64];
  logic        exp_sel = 1'b0;

  lw_sha256_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .cont_i(cont_i), .mode224_i(mode224_i),
    .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o), .rnd_i(rnd_i), .busy_o(busy_o),
    .done_o(done_o), .iv_load_o(iv_load_o), .iv_sel_o(iv_sel_o), .w_wr_o(w_wr_o),
    .w_idx_o(w_idx_o), .w_expand_o(w_expand_o), .rot_o(rot_o), .round_en_o(round_en_o),
    .round_o(round_o), .k_o(k_o), .fin_en_o(fin_en_o), .fin_idx_o(fin_idx_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // K[t] = first 32 fractional bits of cbrt(prime t), refined by Newton steps.
  function automatic logic [31:0] kcalc(input int p);
    real x, f;
    x = $pow(real'(p), 1.0 / 3.0);
    repeat (3) x = x - (x * x * x - real'(p)) / (3.0 * x * x);
    f = x - $floor(x);
    return 32'(longint'($floor(f * 4294967296.0)));
  endfunction

  task automatic drive_junk();
    start_i   = 1'($urandom);
    cont_i    = 1'($urandom);
    mode224_i = 1'($urandom);
  endtask

  task automatic chk_quiet(input string ph);
    chk({ph, "_busy"}, busy_o, 0);
    chk({ph, "_done"}, done_o, 0);
    chk({ph, "_iv"}, iv_load_o, 0);
    chk({ph, "_rdy"}, msg_ready_o, 0);
    chk({ph, "_wwr"}, w_wr_o, 0);
    chk({ph, "_widx"}, w_idx_o, 0);
    chk({ph, "_wexp"}, w_expand_o, 0);
    chk({ph, "_rot"}, rot_o, 0);
    chk({ph, "_ren"}, round_en_o, 0);
    chk({ph, "_rnd"}, round_o, 0);
    chk({ph, "_k"}, k_o, 0);
    chk({ph, "_fen"}, fin_en_o, 0);
    chk({ph, "_fidx"}, fin_idx_o, 0);
  endtask

  // pat: 0 back-to-back words, 1 valid every other cycle, 2 random valid.
  // rfix >= 0 forces rnd_i; abort_at >= 0 returns during that round without finishing.
  task automatic run_block(input bit st, input bit ct, input bit mode, input int pat,
                           input int rfix, input int abort_at);
    int         words, m;
    logic       v;
    logic [4:0] rn;
    @(negedge clk);
    start_i = st; cont_i = ct; mode224_i = mode; msg_valid_i = 1'b0; rnd_i = 5'($urandom);
    #1;
    chk("acc_busy", busy_o, 0);
    chk("acc_iv", iv_load_o, 0);
    if (st) begin
      exp_sel = mode;
      @(negedge clk); drive_junk(); msg_valid_i = 1'($urandom); #1;
      chk("iv_load", iv_load_o, 1);
      chk("iv_busy", busy_o, 1);
      chk("iv_rdy", msg_ready_o, 0);
      chk("iv_wwr", w_wr_o, 0);
      chk("iv_sel", iv_sel_o, exp_sel);
    end
    words = 0; m = 0;
    while (words < 16 && m < 200) begin
      @(negedge clk); drive_junk();
      v  = (pat == 0) ? 1'b1 : (pat == 1) ? ((m % 2) == 0) : 1'($urandom);
      rn = (rfix >= 0) ? 5'(rfix) : 5'($urandom);
      msg_valid_i = v; rnd_i = rn;
      #1;
      chk("msg_rdy", msg_ready_o, 1);
      chk("msg_busy", busy_o, 1);
      chk("msg_iv", iv_load_o, 0);
      chk("msg_wwr", w_wr_o, v);
      chk("msg_rot", rot_o, v ? rn : 5'd0);
      chk("msg_wexp", w_expand_o, 0);
      chk("msg_ren", round_en_o, 0);
      chk("msg_k", k_o, 0);
      if (v) chk("msg_widx", w_idx_o, words);
      words += int'(v); m++;
    end
    for (int r = 0; r < 64; r++) begin
      @(negedge clk); drive_junk(); msg_valid_i = 1'($urandom);
      rn = (rfix >= 0) ? 5'(rfix) : 5'($urandom);
      rnd_i = rn;
      #1;
      chk("rnd_en", round_en_o, 1);
      chk("rnd_t", round_o, r);
      chk("rnd_k", k_o, kref[r]);
      chk("rnd_rdy", msg_ready_o, 0);
      chk("rnd_busy", busy_o, 1);
      chk("rnd_wwr", w_wr_o, r >= 16);
      chk("rnd_wexp", w_expand_o, r >= 16);
      chk("rnd_rot", rot_o, (r >= 16) ? rn : 5'd0);
      if (r >= 16) chk("rnd_widx", w_idx_o, r % 16);
      if (r == 0)  chk("k_t0", k_o, 32'h428a2f98);
      if (r == 16) chk("k_t16", k_o, 32'he49b69c1);
      if (r == 63) chk("k_t63", k_o, 32'hc67178f2);
      if (r == abort_at) return;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); drive_junk(); msg_valid_i = 1'($urandom); rnd_i = 5'($urandom); #1;
      chk("fin_en", fin_en_o, 1);
      chk("fin_idx", fin_idx_o, i);
      chk("fin_ren", round_en_o, 0);
      chk("fin_k", k_o, 0);
      chk("fin_wwr", w_wr_o, 0);
      chk("fin_busy", busy_o, 1);
      chk("fin_done", done_o, 0);
    end
    @(negedge clk);
    start_i = 1'b0; cont_i = 1'b0; msg_valid_i = 1'($urandom); rnd_i = 5'($urandom);
    #1;
    chk("done_pulse", done_o, 1);
    chk("done_busy", busy_o, 0);
    chk("done_fen", fin_en_o, 0);
    chk("done_sel", iv_sel_o, exp_sel);
    @(negedge clk); msg_valid_i = 1'b0; #1;
    chk_quiet("post");
  endtask

  initial begin
    int p, n;
    bit isp;
    p = 2; n = 0;
    while (n < 64) begin
      isp = 1'b1;
      for (int d = 2; d * d <= p; d++) if (p % d == 0) isp = 1'b0;
      if (isp) begin kref[n] = kcalc(p); n++; end
      p++;
    end

    rst = 1'b1; start_i = 1'b0; cont_i = 1'b0; mode224_i = 1'b0; msg_valid_i = 1'b0; rnd_i = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_quiet("rst");
    chk("rst_sel", iv_sel_o, 0);
    rst = 1'b0;

    // cont before any block completes must be ignored
    @(negedge clk); cont_i = 1'b1; #1;
    chk("cont0_busy_a", busy_o, 0);
    @(negedge clk); cont_i = 1'b0; #1;
    chk("cont0_busy_b", busy_o, 0);
    chk("cont0_rdy", msg_ready_o, 0);

    run_block(1'b1, 1'b0, 1'b0, 0, 17, -1);           // SHA-256, back-to-back, rnd 17
    run_block(1'b1, 1'b0, 1'b1, 1, -1, -1);           // SHA-224, toggled valid
    run_block(1'b0, 1'b1, 1'b0, 0, -1, -1);           // chained block, no IV
    run_block(1'b1, 1'b1, 1'($urandom), 0, -1, -1);   // start wins over cont
    run_block(1'b1, 1'b0, 1'($urandom), 2, -1, -1);   // random valid
    run_block(1'b0, 1'b1, 1'b0, 2, -1, -1);           // chained, random valid

    run_block(1'b1, 1'b0, 1'b1, 0, -1, 30);           // abort at round 30
    rst = 1'b1; start_i = 1'b0; cont_i = 1'b0; msg_valid_i = 1'b0; rnd_i = 5'd9;
    @(negedge clk); #1;
    chk_quiet("abort");
    chk("abort_sel", iv_sel_o, 0);
    rst = 1'b0; exp_sel = 1'b0;
    @(negedge clk); cont_i = 1'b1; #1;
    chk("abort_done", done_o, 0);
    @(negedge clk); cont_i = 1'b0; #1;
    chk("abort_cont_busy", busy_o, 0);
    chk("abort_cont_rdy", msg_ready_o, 0);
    chk("abort_done2", done_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
